// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register sentinel, fetch FSM
// states and the per-icode length/field helpers used by the fetch unit.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DONE} fetch_state_e;

    // Unknown icodes are treated as one-byte instructions.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: instr_len = 4'd2;
            IJXX, ICALL:                  instr_len = 4'd9;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:    instr_len = 4'd10;
            default:                      instr_len = 4'd1;
        endcase
    endfunction

    function automatic logic has_regs(input logic [3:0] ic);
        has_regs = ic inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
    endfunction

    function automatic logic has_valC(input logic [3:0] ic);
        has_valC = ic inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
    endfunction

endpackage

// File: rtl/fetch_byte_if.sv
// Single-byte read handshake: raises mem_req one cycle after go, holds the
// address until ack, and gives up after ACK_TIMEOUT unacknowledged cycles.
module fetch_byte_if #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [63:0] addr,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    output logic        hit,
    output logic        tmo
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CW-1:0] wait_cnt;

    assign hit = mem_req & mem_ack;
    // wait_cnt counts completed wait cycles; the last allowed one is ACK_TIMEOUT-1.
    assign tmo = mem_req & ~mem_ack & (wait_cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_addr <= 64'd0;
            wait_cnt <= '0;
        end else if (!mem_req) begin
            if (go) begin
                mem_req  <= 1'b1;
                mem_addr <= addr;
                wait_cnt <= '0;
            end
        end else if (hit || tmo) begin
            mem_req <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Multi-cycle Y86-64 instruction fetch: walks the instruction one byte at a
// time through fetch_byte_if and assembles icode/ifun/rA/rB/valC/valP.
module fetch_seq
    import y86_pkg::*;
#(
    parameter int MEM_BYTES   = 1024,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] PC,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error,
    output logic        busy,
    output logic        done
);

    fetch_state_e state;
    logic [63:0]  pc;
    logic [3:0]   k;
    logic [3:0]   len;
    logic [63:0]  faddr;
    logic         go, hit, tmo;
    logic [3:0]   len_n, voff;
    logic [2:0]   vsel;

    assign faddr = pc + {60'd0, k};
    assign go    = (state == S_REQ) && !mem_req;
    // Byte 0 decides the length in the same cycle it arrives.
    assign len_n = (k == 4'd0) ? instr_len(mem_rdata[7:4]) : len;
    assign voff  = (icode == IJXX || icode == ICALL) ? 4'd1 : 4'd2;
    assign vsel  = 3'(k - voff);

    fetch_byte_if #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_byte (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .addr     (faddr),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .hit      (hit),
        .tmo      (tmo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= 64'd0;
            k           <= 4'd0;
            len         <= 4'd1;
            icode       <= IHALT;
            ifun        <= 4'd0;
            rA          <= RNONE;
            rB          <= RNONE;
            valC        <= 64'd0;
            valP        <= 64'd0;
            instr_valid <= 1'b0;
            imem_error  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc          <= PC;
                        k           <= 4'd0;
                        len         <= 4'd1;
                        icode       <= IHALT;
                        ifun        <= 4'd0;
                        rA          <= RNONE;
                        rB          <= RNONE;
                        valC        <= 64'd0;
                        valP        <= 64'd0;
                        instr_valid <= 1'b0;
                        imem_error  <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (faddr >= 64'(MEM_BYTES)) begin
                        imem_error <= 1'b1;
                        valP       <= pc + 64'(len);
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (hit) begin
                        k <= k + 4'd1;
                        if (k == 4'd0) begin
                            icode       <= mem_rdata[7:4];
                            ifun        <= mem_rdata[3:0];
                            instr_valid <= (mem_rdata[7:4] <= IPOPQ);
                            len         <= len_n;
                        end else if (k == 4'd1 && has_regs(icode)) begin
                            rA <= mem_rdata[7:4];
                            rB <= mem_rdata[3:0];
                        end
                        if (k != 4'd0 && has_valC(icode) && k >= voff)
                            valC[{vsel, 3'b000} +: 8] <= mem_rdata;
                        if (k + 4'd1 == len_n) begin
                            valP  <= pc + 64'(len_n);
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_CHECK;
                        end
                    end else if (tmo) begin
                        imem_error <= 1'b1;
                        valP       <= pc + 64'(len);
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed vector table, randomized fetches against a
// byte-walk reference model, plus timeout, mid-fetch reset and hold sequences.
`timescale 1ns/1ps
module tb_fetch_seq;

    localparam int MB  = 1024;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [63:0] PC;
    logic        mem_req, mem_ack;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid, imem_error, busy, done;

    fetch_seq #(.MEM_BYTES(MB), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .PC(PC),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:MB-1];
    int checks = 0, errors = 0;
    int ack_delay = 0;
    bit no_ack = 0;
    int acks = 0, reqs = 0, req_hi = 0, stab_bad = 0;
    int len_tab [16];
    bit regs_tab [16];

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        int          n;
        int          dly;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        vld, err;
        int          acks;
        int          lat;
    } vec_t;

    vec_t tbl [9];

    // Memory responder: acks after ack_delay visible request cycles, tracks
    // request count, request-high cycles and address stability.
    initial begin
        int wcnt;
        logic prev;
        logic [63:0] held;
        wcnt = 0; prev = 1'b0; held = 64'd0;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                req_hi++;
                if (!prev) begin reqs++; held = mem_addr; end
                else if (mem_addr !== held) stab_bad++;
                if (!no_ack && wcnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (mem_addr < 64'(MB)) ? mem[mem_addr[9:0]] : 8'h00;
                    acks++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            prev = (mem_req === 1'b1);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run_fetch(input logic [63:0] pc, input int dly, input bit spam,
                             output int lat, output int nack, output int nreq,
                             output int nhi, output int nstab, output bit to);
        int a0, r0, h0, s0;
        ack_delay = dly;
        @(negedge clk);
        a0 = acks; r0 = reqs; h0 = req_hi; s0 = stab_bad;
        start = 1'b1; PC = pc;
        @(negedge clk);
        start = 1'b0; lat = 1; to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin to = 1'b0; break; end
            if (spam) begin start = (i % 5 == 2); PC = 64'h10; end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        nack = acks - a0; nreq = reqs - r0; nhi = req_hi - h0; nstab = stab_bad - s0;
    endtask

    task automatic check_vec(input string tg, input vec_t e, input bit spam);
        int lat, na, nr, nh, ns;
        bit to;
        run_fetch(e.pc, e.dly, spam, lat, na, nr, nh, ns, to);
        chk({tg, ".finished"}, 64'(to), 64'd0);
        chk({tg, ".icode"}, 64'(icode), 64'(e.icode));
        chk({tg, ".ifun"}, 64'(ifun), 64'(e.ifun));
        chk({tg, ".rA"}, 64'(rA), 64'(e.ra));
        chk({tg, ".rB"}, 64'(rB), 64'(e.rb));
        chk({tg, ".valC"}, valC, e.valc);
        chk({tg, ".valP"}, valP, e.valp);
        chk({tg, ".instr_valid"}, 64'(instr_valid), 64'(e.vld));
        chk({tg, ".imem_error"}, 64'(imem_error), 64'(e.err));
        chk({tg, ".acks"}, 64'(na), 64'(e.acks));
        chk({tg, ".reqs"}, 64'(nr), 64'(e.acks));
        chk({tg, ".addr_stable"}, 64'(ns), 64'd0);
        chk({tg, ".latency"}, 64'(lat), 64'(e.lat));
    endtask

    // Reference: walk bytes from pc in address order, stopping at the first
    // out-of-range address or once the icode-determined length is reached.
    function automatic vec_t model(input logic [63:0] pc, input int dly);
        vec_t e;
        logic [7:0]  b [10];
        bit          ok [10];
        logic [63:0] a;
        logic [3:0]  ic;
        int          L, f, off;
        for (int j = 0; j < 10; j++) begin
            a = pc + 64'(j);
            ok[j] = (a < 64'(MB));
            b[j] = ok[j] ? mem[a[9:0]] : 8'h00;
        end
        ic = ok[0] ? b[0][7:4] : 4'h0;
        L = len_tab[ic];
        f = 0;
        while (f < L && ok[f]) f++;
        e.pc = pc; e.bytes = 80'd0; e.n = 0; e.dly = dly;
        e.icode = (f > 0) ? b[0][7:4] : 4'h0;
        e.ifun  = (f > 0) ? b[0][3:0] : 4'h0;
        e.vld   = (f > 0) && (ic <= 4'hB);
        e.ra = 4'hF; e.rb = 4'hF;
        if (regs_tab[ic] && f > 1) begin e.ra = b[1][7:4]; e.rb = b[1][3:0]; end
        e.valc = 64'd0;
        off = (ic == 4'h7 || ic == 4'h8) ? 1 : 2;
        if (L >= 9)
            for (int j = off; j < f; j++) e.valc[8*(j-off) +: 8] = b[j];
        e.valp = pc + 64'(L);
        e.err  = (f < L);
        e.acks = f;
        e.lat  = 1 + (3 + dly) * f + ((f < L) ? 1 : 0);
        return e;
    endfunction

    task automatic load_bytes(input logic [63:0] pc, input logic [79:0] bytes, input int n);
        logic [63:0] a;
        for (int i = 0; i < n; i++) begin
            a = pc + 64'(i);
            if (a < 64'(MB)) mem[a[9:0]] = bytes[79-8*i -: 8];
        end
    endtask

    initial begin
        logic [63:0] rpc, a;
        int lat, na, nr, nh, ns, d;
        bit to, found;
        vec_t e;

        len_tab  = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
        regs_tab = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < MB; i++) mem[i] = 8'h00;

        //          pc        bytes                      n  d  ic    ifun  rA    rB    valC                    valP      v  e  acks lat
        tbl[0] = '{64'h0,   80'h00000000000000000000,  1, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                64'h1,    1, 0, 1,  4};
        tbl[1] = '{64'h10,  80'h30F3EFCDAB8967452301, 10, 0, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h1A,   1, 0, 10, 31};
        tbl[2] = '{64'h20,  80'h73000100000000000000,  9, 2, 4'h7, 4'h3, 4'hF, 4'hF, 64'h100,              64'h29,   1, 0, 9,  46};
        tbl[3] = '{64'd1022,80'h30F30000000000000000,  2, 0, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0,                64'd1032, 1, 1, 2,  8};
        tbl[4] = '{64'h30,  80'hC0000000000000000000,  1, 0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0,                64'h31,   0, 0, 1,  4};
        tbl[5] = '{64'h40,  80'h20120000000000000000,  2, 1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0,                64'h42,   1, 0, 2,  9};
        tbl[6] = '{64'h3FE, 80'hA05F0000000000000000,  2, 0, 4'hA, 4'h0, 4'h5, 4'hF, 64'h0,                64'h400,  1, 0, 2,  7};
        tbl[7] = '{64'h400, 80'h00000000000000000000,  0, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                64'h401,  0, 1, 0,  2};
        tbl[8] = '{64'h3F8, 80'h50121122334455660000,  8, 1, 4'h5, 4'h0, 4'h1, 4'h2, 64'h0000665544332211, 64'h402,  1, 1, 8,  34};

        reset = 1'b1; start = 1'b0; PC = 64'd0;
        repeat (3) @(negedge clk);
        chk("reset.icode", 64'(icode), 64'h0);
        chk("reset.rA", 64'(rA), 64'hF);
        chk("reset.rB", 64'(rB), 64'hF);
        chk("reset.valC", valC, 64'h0);
        chk("reset.valP", valP, 64'h0);
        chk("reset.flags", {60'd0, instr_valid, imem_error, busy, done}, 64'h0);
        chk("reset.mem_req", 64'(mem_req), 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            load_bytes(tbl[i].pc, tbl[i].bytes, tbl[i].n);
            check_vec($sformatf("vec%0d", i), tbl[i], 1'b0);
        end

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       rpc = 64'(MB) - 64'($urandom_range(1, 10));
                1:       rpc = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
                default: rpc = 64'($urandom_range(0, MB - 1));
            endcase
            for (int j = 0; j < 10; j++) begin
                a = rpc + 64'(j);
                if (a < 64'(MB)) mem[a[9:0]] = 8'($urandom);
            end
            d = $urandom_range(0, 3);
            e = model(rpc, d);
            check_vec($sformatf("rnd%0d", it), e, 1'b0);
        end

        // Byte 0 never acknowledged.
        mem[10'h60] = 8'h30;
        no_ack = 1'b1;
        run_fetch(64'h60, 0, 1'b0, lat, na, nr, nh, ns, to);
        no_ack = 1'b0;
        chk("tmo.finished", 64'(to), 64'd0);
        chk("tmo.imem_error", 64'(imem_error), 64'd1);
        chk("tmo.req_cycles", 64'(nh), 64'(TMO));
        chk("tmo.reqs", 64'(nr), 64'd1);
        chk("tmo.acks", 64'(na), 64'd0);
        chk("tmo.mem_req_low", 64'(mem_req), 64'd0);
        chk("tmo.valP", valP, 64'h61);
        chk("tmo.instr_valid", 64'(instr_valid), 64'd0);
        chk("tmo.latency", 64'(lat), 64'(3 + TMO));

        // Reset while byte 4 of an rmmovq is outstanding.
        load_bytes(64'h80, 80'h40128877665544332211, 10);
        ack_delay = 0;
        @(negedge clk); start = 1'b1; PC = 64'h80;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mem_req && mem_addr == 64'h84) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("rst.reach_byte4", 64'(found), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst.mem_req", 64'(mem_req), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.rA", 64'(rA), 64'hF);
        chk("rst.icode", 64'(icode), 64'h0);
        chk("rst.valC", valC, 64'h0);
        @(negedge clk); reset = 1'b0;

        // Clean fetch afterwards, with start pulsed (PC=0x10) while busy.
        load_bytes(64'h90, tbl[1].bytes, 10);
        e = tbl[1]; e.pc = 64'h90; e.valp = 64'h9A;
        check_vec("spam", e, 1'b1);

        repeat (5) @(negedge clk);
        chk("hold.valP", valP, 64'h9A);
        chk("hold.rB", 64'(rB), 64'h3);
        chk("hold.busy_done", {62'd0, busy, done}, 64'd0);

        mem[0] = 8'h00;
        start = 1'b1; PC = 64'h0;
        @(negedge clk); start = 1'b0;
        chk("clr.icode", 64'(icode), 64'h0);
        chk("clr.rB", 64'(rB), 64'hF);
        chk("clr.valC", valC, 64'h0);
        chk("clr.valP", valP, 64'h0);
        chk("clr.busy", 64'(busy), 64'd1);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("clr.done_seen", 64'(found), 64'd1);
        chk("clr.valP_final", valP, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
